// File: rtl/uart_alu_sequencer_pkg.sv
// Shared types and constants for the UART-to-ALU frame sequencer.
package uart_alu_sequencer_pkg;

  localparam int DBIT_DEF = 8;
  localparam int OPW_DEF  = 6;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    CALC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam logic [OPW_DEF-1:0] OP_ADD = 6'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB = 6'd1;
  localparam logic [OPW_DEF-1:0] OP_AND = 6'd2;
  localparam logic [OPW_DEF-1:0] OP_OR  = 6'd3;
  localparam logic [OPW_DEF-1:0] OP_XOR = 6'd4;

  // States in which the inter-byte timeout is armed.
  function automatic logic is_wait_state(state_t s);
    return (s == GET_B) || (s == GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_if.sv
// Bundles the rx FIFO, ALU and tx FIFO signals seen by the sequencer.
interface uart_alu_sequencer_if #(
  parameter int DBIT = 8,
  parameter int OPW  = 6
);
  logic            rx_empty;
  logic [DBIT-1:0] r_data;
  logic            rd;
  logic [DBIT-1:0] a;
  logic [DBIT-1:0] b;
  logic [OPW-1:0]  op;
  logic [DBIT-1:0] alu_result;
  logic            tx_full;
  logic            wr;
  logic [DBIT-1:0] w_data;

  modport master (
    input  rx_empty, r_data, alu_result, tx_full,
    output rd, a, b, op, wr, w_data
  );

  modport slave (
    output rx_empty, r_data, alu_result, tx_full,
    input  rd, a, b, op, wr, w_data
  );
endinterface

// File: rtl/uart_alu_sequencer_timeout_counter.sv
// Inter-byte idle counter; o_tc flags that TIMEOUT-1 idle cycles have elapsed.
module uart_alu_sequencer_timeout_counter #(
  parameter int TIMEOUT = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);
  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/uart_alu_sequencer.sv
// Pops A, B, opcode from the rx FIFO, latches the ALU result and pushes it to
// the tx FIFO; an inter-byte timeout drops a stalled frame back to GET_A.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_alu_sequencer_if.master  bus,
  output logic [DBIT-1:0]       leds,
  output logic                  frame_err,
  output logic                  busy
);

  state_t          r_state, w_next;
  logic [DBIT-1:0] r_a, r_b, r_wdata, r_leds;
  logic [OPW-1:0]  r_op;
  logic            w_rd, w_wr, w_timeout, w_tc, w_wait, w_clear;

  assign w_wait  = is_wait_state(r_state);
  assign w_clear = !w_wait || w_rd || w_timeout;

  uart_alu_sequencer_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_clear  (w_clear),
    .i_enable (w_wait && bus.rx_empty),
    .o_tc     (w_tc)
  );

  // A byte landing in the terminal-count cycle is left in the FIFO as the next A.
  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_wr      = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      GET_A: begin
        if (!bus.rx_empty) begin
          w_rd   = 1'b1;
          w_next = GET_B;
        end
      end
      GET_B, GET_OP: begin
        if (w_tc) begin
          w_timeout = 1'b1;
          w_next    = GET_A;
        end else if (!bus.rx_empty) begin
          w_rd   = 1'b1;
          w_next = (r_state == GET_B) ? GET_OP : CALC;
        end
      end
      CALC: w_next = SEND;
      SEND: begin
        if (!bus.tx_full) begin
          w_wr   = 1'b1;
          w_next = GET_A;
        end
      end
      default: w_next = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= GET_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_wdata <= '0;
      r_leds  <= '0;
    end else begin
      if (w_rd) begin
        case (r_state)
          GET_A:   r_a  <= bus.r_data;
          GET_B:   r_b  <= bus.r_data;
          GET_OP:  r_op <= bus.r_data[OPW-1:0];
          default: r_a  <= r_a;
        endcase
      end
      if (r_state == CALC) r_wdata <= bus.alu_result;
      if (w_wr)            r_leds  <= r_wdata;
    end
  end

  // Strobes are masked while reset is held so the FIFOs are never touched.
  assign bus.rd     = w_rd && reset;
  assign bus.wr     = w_wr && reset;
  assign frame_err  = w_timeout && reset;
  assign bus.a      = r_a;
  assign bus.b      = r_b;
  assign bus.op     = r_op;
  assign bus.w_data = r_wdata;
  assign leds       = r_leds;
  assign busy       = (r_state != GET_A);

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomised self-checking bench: FIFO/ALU environment, event monitor and a
// frame-level reference model (every 3 bytes -> one ALU result written).
module tb_uart_alu_sequencer;
  import uart_alu_sequencer_pkg::*;

  localparam int DBIT    = 8;
  localparam int OPW     = 6;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [DBIT-1:0] leds;
  logic            frame_err;
  logic            busy;

  uart_alu_sequencer_if #(.DBIT(DBIT), .OPW(OPW)) bus ();

  uart_alu_sequencer #(.DBIT(DBIT), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .leds      (leds),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int viol   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] push_q[$];
  int         rd_log[$];
  logic [7:0] rd_dat[$];
  int         wr_cyc[$];
  logic [7:0] wr_dat[$];
  int         fe_log[$];

  function automatic logic [7:0] alu_f(logic [7:0] x, logic [7:0] y, logic [5:0] o);
    case (o)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      default: return x;
    endcase
  endfunction

  assign bus.alu_result = alu_f(bus.a, bus.b, bus.op);

  always @(posedge clk) cyc++;

  // rx FIFO: pops what the DUT saw at the edge, then admits newly pushed bytes.
  initial begin
    logic do_pop;
    bus.rx_empty = 1'b1;
    bus.r_data   = '0;
    forever begin
      @(posedge clk);
      do_pop = bus.rd;
      #1;
      if (do_pop && rx_q.size() > 0) void'(rx_q.pop_front());
      while (push_q.size() > 0) rx_q.push_back(push_q.pop_front());
      bus.rx_empty = (rx_q.size() == 0);
      bus.r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (bus.rd) begin
      rd_log.push_back(cyc);
      rd_dat.push_back(bus.r_data);
    end
    if (bus.rd && bus.rx_empty) viol++;
    if (bus.wr && bus.tx_full)  viol++;
    if (bus.rd && bus.wr)       viol++;
    if (bus.wr) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(bus.w_data);
    end
    if (frame_err) fe_log.push_back(cyc);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); rd_dat.delete();
    wr_cyc.delete(); wr_dat.delete();
    fe_log.delete(); viol = 0;
  endtask

  task automatic wait_rd(int n, int budget);
    for (int i = 0; i < budget && rd_log.size() < n; i++) tick(1);
  endtask

  task automatic wait_wr(int n, int budget);
    for (int i = 0; i < budget && wr_cyc.size() < n; i++) tick(1);
    tick(2);
  endtask

  function automatic logic [7:0] rnd_op_byte();
    logic [1:0] hi = 2'($urandom);
    logic [5:0] lo = 6'($urandom_range(0, 5));
    return {hi, lo};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.tx_full = 1'b0;
    tick(3);
    checks++;
    if ({bus.a, bus.b, bus.op, bus.w_data, leds} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h required 0", {bus.a, bus.b, bus.op, bus.w_data, leds});
    end
    checks++;
    if ({bus.rd, bus.wr, frame_err, busy} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {bus.rd, bus.wr, frame_err, busy});
    end
    reset = 1'b1;
    tick(2);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    push_q.push_back(8'h05); push_q.push_back(8'h03); push_q.push_back({2'b00, OP_ADD});
    wait_wr(1, 30);
    checks++;
    if (rd_log.size() != 3 || wr_cyc.size() != 1) begin
      errors++;
      $display("FAIL basic_counts: got rd=%0d wr=%0d required rd=3 wr=1", rd_log.size(), wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[0] - rd_log[2] != 2 || rd_log[2] - rd_log[0] != 2) begin
        errors++;
        $display("FAIL basic_latency: got rd->wr %0d span %0d required 2 2",
                 wr_cyc[0] - rd_log[2], rd_log[2] - rd_log[0]);
      end
      checks++;
      if (wr_dat[0] !== 8'h08) begin
        errors++;
        $display("FAIL basic_wdata: got %0h required 08", wr_dat[0]);
      end
    end
    checks++;
    if (leds !== 8'h08 || busy !== 1'b0 || viol != 0) begin
      errors++;
      $display("FAIL basic_leds: got leds=%0h busy=%b viol=%0d required 08 0 0", leds, busy, viol);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] x, y, o, exp_r;
    int rel;
    clear_logs();
    x = 8'($urandom); y = 8'($urandom); o = rnd_op_byte();
    exp_r = alu_f(x, y, o[5:0]);
    bus.tx_full = 1'b1;
    push_q.push_back(x); push_q.push_back(y); push_q.push_back(o);
    tick(16);
    checks++;
    if (wr_cyc.size() != 0 || busy !== 1'b1 || bus.w_data !== exp_r) begin
      errors++;
      $display("FAIL bp_hold: got wr=%0d busy=%b w_data=%0h required 0 1 %0h",
               wr_cyc.size(), busy, bus.w_data, exp_r);
    end
    bus.tx_full = 1'b0;
    rel = cyc;
    tick(3);
    checks++;
    if (wr_cyc.size() != 1) begin
      errors++;
      $display("FAIL bp_wr_count: got %0d required 1", wr_cyc.size());
    end else begin
      checks++;
      if (wr_cyc[0] != rel || wr_dat[0] !== exp_r || leds !== exp_r) begin
        errors++;
        $display("FAIL bp_release: got cyc=%0d data=%0h leds=%0h required %0d %0h %0h",
                 wr_cyc[0], wr_dat[0], leds, rel, exp_r, exp_r);
      end
    end
  endtask

  task automatic test_timeout();
    clear_logs();
    push_q.push_back(8'hAA);
    tick(25);
    checks++;
    if (rd_log.size() != 1 || fe_log.size() != 1) begin
      errors++;
      $display("FAIL to_counts: got rd=%0d fe=%0d required 1 1", rd_log.size(), fe_log.size());
    end else begin
      checks++;
      if (fe_log[0] - rd_log[0] != TIMEOUT) begin
        errors++;
        $display("FAIL to_delay: got %0d required %0d", fe_log[0] - rd_log[0], TIMEOUT);
      end
    end
    checks++;
    if (busy !== 1'b0 || bus.a !== 8'hAA) begin
      errors++;
      $display("FAIL to_state: got busy=%b a=%0h required 0 aa", busy, bus.a);
    end
    clear_logs();
    push_q.push_back(8'h01); push_q.push_back(8'h02); push_q.push_back({2'b00, OP_SUB});
    wait_wr(1, 30);
    checks++;
    if (wr_cyc.size() != 1 || fe_log.size() != 0) begin
      errors++;
      $display("FAIL to_recover_count: got wr=%0d fe=%0d required 1 0", wr_cyc.size(), fe_log.size());
    end else begin
      checks++;
      if (wr_dat[0] !== 8'hFF) begin
        errors++;
        $display("FAIL to_recover_data: got %0h required ff", wr_dat[0]);
      end
    end
  endtask

  task automatic test_slow();
    logic [7:0] bytes[3];
    int r;
    clear_logs();
    bytes[0] = 8'($urandom); bytes[1] = 8'($urandom); bytes[2] = rnd_op_byte();
    push_q.push_back(bytes[0]);
    for (int k = 1; k < 3; k++) begin
      wait_rd(k, 20);
      r = (rd_log.size() >= k) ? rd_log[k-1] : cyc;
      while (cyc < r + TIMEOUT - 2) tick(1);
      push_q.push_back(bytes[k]);
    end
    wait_wr(1, 30);
    checks++;
    if (fe_log.size() != 0 || wr_cyc.size() != 1) begin
      errors++;
      $display("FAIL slow_counts: got fe=%0d wr=%0d required 0 1", fe_log.size(), wr_cyc.size());
    end else begin
      checks++;
      if (wr_dat[0] !== alu_f(bytes[0], bytes[1], bytes[2][5:0]) || rd_log[1] - rd_log[0] != TIMEOUT - 1) begin
        errors++;
        $display("FAIL slow_result: got %0h gap %0d required %0h gap %0d", wr_dat[0],
                 rd_log[1] - rd_log[0], alu_f(bytes[0], bytes[1], bytes[2][5:0]), TIMEOUT - 1);
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] x, y, z1, z2;
    int r;
    clear_logs();
    x = 8'($urandom); y = 8'($urandom); z1 = 8'($urandom); z2 = rnd_op_byte();
    push_q.push_back(x);
    wait_rd(1, 20);
    r = (rd_log.size() >= 1) ? rd_log[0] : cyc;
    while (cyc < r + TIMEOUT - 1) tick(1);
    push_q.push_back(y);
    tick(3);
    checks++;
    if (fe_log.size() != 1 || rd_log.size() != 2) begin
      errors++;
      $display("FAIL coll_counts: got fe=%0d rd=%0d required 1 2", fe_log.size(), rd_log.size());
    end else begin
      checks++;
      if (fe_log[0] != r + TIMEOUT || rd_log[1] != r + TIMEOUT + 1 || rd_dat[1] !== y) begin
        errors++;
        $display("FAIL coll_order: got fe=%0d rd=%0d byte=%0h required %0d %0d %0h",
                 fe_log[0], rd_log[1], rd_dat[1], r + TIMEOUT, r + TIMEOUT + 1, y);
      end
    end
    push_q.push_back(z1); push_q.push_back(z2);
    wait_wr(1, 30);
    checks++;
    if (wr_cyc.size() != 1 || (wr_dat.size() > 0 && wr_dat[0] !== alu_f(y, z1, z2[5:0]))) begin
      errors++;
      $display("FAIL coll_result: got wr=%0d required 1 with %0h", wr_cyc.size(), alu_f(y, z1, z2[5:0]));
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v[6];
    clear_logs();
    for (int i = 0; i < 6; i++) v[i] = (i % 3 == 2) ? rnd_op_byte() : 8'($urandom);
    for (int i = 0; i < 6; i++) push_q.push_back(v[i]);
    wait_wr(2, 40);
    checks++;
    if (wr_cyc.size() != 2 || rd_log.size() != 6 || viol != 0) begin
      errors++;
      $display("FAIL b2b_counts: got wr=%0d rd=%0d viol=%0d required 2 6 0", wr_cyc.size(), rd_log.size(), viol);
    end else begin
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != 5) begin
        errors++;
        $display("FAIL b2b_period: got %0d required 5", wr_cyc[1] - wr_cyc[0]);
      end
      checks++;
      if (wr_dat[0] !== alu_f(v[0], v[1], v[2][5:0]) || wr_dat[1] !== alu_f(v[3], v[4], v[5][5:0])) begin
        errors++;
        $display("FAIL b2b_data: got %0h %0h required %0h %0h", wr_dat[0], wr_dat[1],
                 alu_f(v[0], v[1], v[2][5:0]), alu_f(v[3], v[4], v[5][5:0]));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p, q, s;
    clear_logs();
    push_q.push_back(8'($urandom | 1)); push_q.push_back(8'($urandom | 1));
    wait_rd(2, 20);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.a, bus.b, busy, bus.rd, bus.wr} !== '0) begin
      errors++;
      $display("FAIL rst_mid_zero: got a=%0h b=%0h busy=%b required 0 0 0", bus.a, bus.b, busy);
    end
    p = 8'($urandom); q = 8'($urandom); s = rnd_op_byte();
    push_q.push_back(p); push_q.push_back(q); push_q.push_back(s);
    tick(4);
    checks++;
    if (rd_log.size() != 2 || rx_q.size() != 3 || wr_cyc.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_hold: got rd=%0d fifo=%0d wr=%0d required 2 3 0",
               rd_log.size(), rx_q.size(), wr_cyc.size());
    end
    reset = 1'b1;
    wait_wr(1, 30);
    checks++;
    if (wr_cyc.size() != 1 || rd_log.size() != 5 ||
        (wr_dat.size() > 0 && wr_dat[0] !== alu_f(p, q, s[5:0]))) begin
      errors++;
      $display("FAIL rst_mid_fresh: got wr=%0d rd=%0d required 1 5 data %0h",
               wr_cyc.size(), rd_log.size(), alu_f(p, q, s[5:0]));
    end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    logic [7:0] exp_q[$];
    int idx = 0;
    clear_logs();
    for (int f = 0; f < 10; f++) begin
      logic [7:0] x = 8'($urandom), y = 8'($urandom), o = rnd_op_byte();
      bytes.push_back(x); bytes.push_back(y); bytes.push_back(o);
      exp_q.push_back(alu_f(x, y, o[5:0]));
    end
    for (int c = 0; c < 400 && idx < bytes.size(); c++) begin
      bus.tx_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        push_q.push_back(bytes[idx]);
        idx++;
      end
      tick(1);
    end
    bus.tx_full = 1'b0;
    wait_wr(10, 200);
    checks++;
    if (wr_cyc.size() != 10 || fe_log.size() != 0 || viol != 0) begin
      errors++;
      $display("FAIL rand_counts: got wr=%0d fe=%0d viol=%0d required 10 0 0",
               wr_cyc.size(), fe_log.size(), viol);
    end
    for (int i = 0; i < 10 && i < wr_dat.size(); i++) begin
      checks++;
      if (wr_dat[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %0h required %0h", i, wr_dat[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_slow();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
